// File: rtl/pipelined_addsub.sv
// Carry-segmented adder/subtractor pipeline with a valid/ready handshake.
// Stage k adds operand segment k using the carry registered by stage k-1.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
  localparam int STAGES   = WIDTH / SEG_SAFE;
  localparam int LAST     = STAGES - 1;

  if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_param_check
    $error("pipelined_addsub: SEG must be >= 1 and divide WIDTH evenly");
  end

  logic              w_advance;
  logic [STAGES-1:0] w_v_in;
  logic [STAGES-1:0] w_c_in;
  logic [WIDTH-1:0]  w_a_in  [STAGES];
  logic [WIDTH-1:0]  w_b_in  [STAGES];
  logic [WIDTH-1:0]  w_s_in  [STAGES];
  logic [WIDTH-1:0]  w_s_out [STAGES];
  logic [SEG_SAFE:0] w_seg   [STAGES];
  logic              w_c_msb;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic              r_ovf;
  logic              r_zero;

  assign w_advance = !r_valid[LAST] || out_ready;
  assign in_ready  = w_advance;

  // Subtraction is folded in at entry: b is inverted and the carry forced to 1.
  always_comb begin
    w_v_in    = '0;
    w_c_in    = '0;
    w_v_in[0] = in_valid;
    w_c_in[0] = sub ? 1'b1 : c_in;
    w_a_in[0] = a;
    w_b_in[0] = sub ? ~b : b;
    w_s_in[0] = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_v_in[k] = r_valid[k-1];
      w_c_in[k] = r_carry[k-1];
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_s_in[k] = r_sum[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_seg[k] = {1'b0, w_a_in[k][k*SEG_SAFE +: SEG_SAFE]}
               + {1'b0, w_b_in[k][k*SEG_SAFE +: SEG_SAFE]}
               + {{SEG_SAFE{1'b0}}, w_c_in[k]};
      w_s_out[k] = w_s_in[k];
      w_s_out[k][k*SEG_SAFE +: SEG_SAFE] = w_seg[k][SEG_SAFE-1:0];
    end
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    w_c_msb = w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1] ^ w_s_out[LAST][WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_carry <= '0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (w_advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_v_in[k];
        if (w_v_in[k]) begin
          r_carry[k] <= w_seg[k][SEG_SAFE];
          r_a[k]     <= w_a_in[k];
          r_b[k]     <= w_b_in[k];
          r_sum[k]   <= w_s_out[k];
        end
      end
      if (w_v_in[LAST]) begin
        r_ovf  <= w_c_msb ^ w_seg[LAST][SEG_SAFE];
        r_zero <= (w_s_out[LAST] == '0);
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign sum       = r_sum[LAST];
  assign c_out     = r_carry[LAST];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
